// File: rtl/arb_pkg.sv
// Shared definitions for the dispatch arbiter and its per-core instruction FIFOs.
package arb_pkg;

    localparam int INSTR_W    = 32;
    localparam int FIFO_DEPTH = 8;
    localparam int FIFO_AF    = 6;

    typedef logic [INSTR_W-1:0] instr_t;

endpackage

// File: rtl/core_instr_fifo_if.sv
// Handshake bundle between the arbiter/fetch side (master) and the FIFO (slave).
interface core_instr_fifo_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic             rd_ready;
    logic             rd_valid;
    logic [WIDTH-1:0] rd_data;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             clr_overflow;

    modport master (
        output wr_en, wr_data, rd_ready, clr_overflow,
        input  rd_valid, rd_data, full, empty, almost_full, count, overflow
    );

    modport slave (
        input  wr_en, wr_data, rd_ready, clr_overflow,
        output rd_valid, rd_data, full, empty, almost_full, count, overflow
    );

endinterface

// File: rtl/fifo_ptr.sv
// Wrap-bit pointer: the MSB toggles each time the low bits roll over, so
// full and empty are distinguishable with equal low bits.
module fifo_ptr #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         inc,
    output logic [W-1:0] ptr
);

    // Advance on increment; wraps naturally at 2**W.
    always_ff @(posedge clk or negedge resetn) begin
        // NOTE: sequential state uses non-blocking assignment so every flop
        // samples pre-edge values regardless of block evaluation order.
        if (!resetn) ptr <= '0;
        else if (inc) ptr <= ptr + W'(1);
    end

endmodule

// File: rtl/core_instr_fifo.sv
// Per-core first-word-fall-through instruction queue with occupancy flags
// and a sticky overflow indicator for pushes dropped while full.
module core_instr_fifo
    import arb_pkg::*;
#(
    parameter int WIDTH     = INSTR_W,
    parameter int DEPTH     = FIFO_DEPTH,
    parameter int AF_THRESH = FIFO_AF
) (
    input  logic             clk,
    input  logic             resetn,
    core_instr_fifo_if.slave bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] AF_CNT  = PW'(AF_THRESH);
    localparam logic [PW-1:0] FULL_CNT = PW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    count;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             drop;
    logic             overflow;

    // Flags derive only from registered pointers, so they never glitch on inputs.
    assign count = wr_ptr - rd_ptr;
    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);

    // Qualify push/pop; a pop in the same cycle frees the slot for a push when full.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned and a latch is never inferred.
        pop  = 1'b0;
        push = 1'b0;
        drop = 1'b0;
        pop  = !empty && bus.rd_ready;
        push = bus.wr_en && (!full || pop);
        drop = bus.wr_en && !push;
    end

    fifo_ptr #(.W(PW)) u_wr_ptr (
        .clk    (clk),
        .resetn (resetn),
        .inc    (push),
        .ptr    (wr_ptr)
    );

    fifo_ptr #(.W(PW)) u_rd_ptr (
        .clk    (clk),
        .resetn (resetn),
        .inc    (pop),
        .ptr    (rd_ptr)
    );

    // Storage write on accepted push.
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset; validity is tracked by the pointers and
        // rd_data is masked when empty, so stale words are never visible.
        if (push) mem[wr_ptr[AW-1:0]] <= bus.wr_data;
    end

    // Sticky overflow: a dropped push wins over a same-cycle clear.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)               overflow <= 1'b0;
        else if (drop)             overflow <= 1'b1;
        else if (bus.clr_overflow) overflow <= 1'b0;
    end

    assign bus.rd_valid    = !empty;
    assign bus.rd_data     = empty ? '0 : mem[rd_ptr[AW-1:0]];
    assign bus.full        = full;
    assign bus.empty       = empty;
    assign bus.almost_full = (count >= AF_CNT);
    assign bus.count       = count;
    assign bus.overflow    = overflow;

endmodule

// File: tb/tb_core_instr_fifo.sv
// Directed bench for core_instr_fifo: a vector table for the fill/drain/overflow
// walk, plus hand-written streaming and asynchronous-reset sequences.
module tb_core_instr_fifo;

    typedef struct {
        logic        wr_en;
        logic [31:0] wr_data;
        logic        rd_ready;
        logic        clr;
        int          cnt;
        logic [31:0] data;
        logic        ovf;
    } vec_t;

    logic clk    = 1'b0;
    logic resetn = 1'b1;
    int   checks = 0;
    int   errors = 0;
    vec_t vecs[$];

    core_instr_fifo_if #(.WIDTH(32), .DEPTH(8)) bus ();

    core_instr_fifo #(.WIDTH(32), .DEPTH(8), .AF_THRESH(6)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void add(input logic we, input logic [31:0] wd, input logic rr,
                                input logic clr, input int cnt, input logic [31:0] d,
                                input logic ovf);
        vec_t v;
        v.wr_en = we; v.wr_data = wd; v.rd_ready = rr; v.clr = clr;
        v.cnt = cnt; v.data = d; v.ovf = ovf;
        vecs.push_back(v);
    endfunction

    task automatic drive(input logic we, input logic [31:0] wd, input logic rr, input logic clr);
        bus.wr_en = we; bus.wr_data = wd; bus.rd_ready = rr; bus.clr_overflow = clr;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Compare the full flag set against an expected occupancy/head/overflow.
    task automatic check_state(input string tag, input int cnt, input logic [31:0] d, input logic ovf);
        check({tag, ".count"},       64'(bus.count),       64'(cnt));
        check({tag, ".rd_valid"},    64'(bus.rd_valid),    64'(cnt != 0));
        check({tag, ".empty"},       64'(bus.empty),       64'(cnt == 0));
        check({tag, ".full"},        64'(bus.full),        64'(cnt == 8));
        check({tag, ".almost_full"}, 64'(bus.almost_full), 64'(cnt >= 6));
        check({tag, ".rd_data"},     64'(bus.rd_data),     64'(d));
        check({tag, ".overflow"},    64'(bus.overflow),    64'(ovf));
    endtask

    initial begin
        // Basic three-word push then drain, including a read while empty.
        add(1, 32'h1111_1111, 0, 0, 1, 32'h1111_1111, 0);
        add(1, 32'h2222_2222, 0, 0, 2, 32'h1111_1111, 0);
        add(1, 32'h3333_3333, 0, 0, 3, 32'h1111_1111, 0);
        add(0, 32'h0,         1, 0, 2, 32'h2222_2222, 0);
        add(0, 32'h0,         1, 0, 1, 32'h3333_3333, 0);
        add(0, 32'h0,         1, 0, 0, 32'h0,         0);
        add(0, 32'h0,         1, 0, 0, 32'h0,         0);
        // Fill to eight; almost_full at six, full at eight.
        for (int i = 0; i < 8; i++)
            add(1, 32'hA000_0000 + 32'(i), 0, 0, i + 1, 32'hA000_0000, 0);
        // Dropped push while full.
        add(1, 32'hDEAD_BEEF, 0, 0, 8, 32'hA000_0000, 1);
        // Clear overflow.
        add(0, 32'h0,         0, 1, 8, 32'hA000_0000, 0);
        // Push and pop together while full: accepted, no overflow.
        add(1, 32'hB0B0_B0B0, 1, 0, 8, 32'hA000_0001, 0);
        // Clear coincident with a dropped push: set wins.
        add(1, 32'h1234_5678, 0, 1, 8, 32'hA000_0001, 1);
        add(0, 32'h0,         0, 1, 8, 32'hA000_0001, 0);
        // Drain: A2..A7, then the word pushed while full, then empty.
        for (int i = 2; i < 8; i++)
            add(0, 32'h0, 1, 0, 9 - i, 32'hA000_0000 + 32'(i), 0);
        add(0, 32'h0, 1, 0, 1, 32'hB0B0_B0B0, 0);
        add(0, 32'h0, 1, 0, 0, 32'h0,         0);

        drive(0, 32'h0, 0, 0);
        #2 resetn = 1'b0;
        #1 check_state("reset", 0, 32'h0, 0);
        step();
        @(negedge clk);
        resetn = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].wr_en, vecs[i].wr_data, vecs[i].rd_ready, vecs[i].clr);
            step();
            check_state($sformatf("v%0d", i), vecs[i].cnt, vecs[i].data, vecs[i].ovf);
        end

        // Streaming across pointer wrap: one push and one pop per cycle.
        for (int i = 0; i < 20; i++) begin
            if (i > 0) check($sformatf("stream_pre%0d.rd_data", i), 64'(bus.rd_data),
                             64'(32'hC000_0000 + 32'(i - 1)));
            drive(1, 32'hC000_0000 + 32'(i), 1, 0);
            step();
            check($sformatf("stream%0d.count_le1", i), 64'(bus.count <= 1), 64'(1));
            check($sformatf("stream%0d.rd_data", i), 64'(bus.rd_data), 64'(32'hC000_0000 + 32'(i)));
        end
        drive(0, 32'h0, 1, 0);
        step();
        check_state("stream_end", 0, 32'h0, 0);

        // Asynchronous reset with five entries queued.
        for (int i = 0; i < 5; i++) begin
            drive(1, 32'hE000_0000 + 32'(i), 0, 0);
            step();
        end
        drive(0, 32'h0, 0, 0);
        check_state("pre_reset", 5, 32'hE000_0000, 0);
        @(negedge clk);
        #2 resetn = 1'b0;
        #1 check_state("async_reset", 0, 32'h0, 0);
        @(negedge clk);
        resetn = 1'b1;
        drive(1, 32'hF00D_F00D, 0, 0);
        step();
        check_state("post_reset_push", 1, 32'hF00D_F00D, 0);
        drive(0, 32'h0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/core_instr_fifo.md
# core_instr_fifo

Per-core instruction queue sitting directly downstream of the dispatch arbiter: one instance per core, written with the arbiter's `instr_out` whenever that core's `FIFO_n_en` strobe is high, and drained by the core's fetch stage over a valid/ready handshake. It is first-word-fall-through, reports occupancy and backpressure, and latches a sticky overflow flag when a write arrives while full.

## Interface
- `WIDTH`, 32, instruction word width
- `DEPTH`, 8, number of entries; power of two, ≥ 2
- `AF_THRESH`, 6, `almost_full` asserts when `count` ≥ this value; must satisfy 1 ≤ `AF_THRESH` ≤ `DEPTH`

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge
- `resetn`  in  1  reset, asynchronous assert, active-low
- `wr_en`  in  1  push strobe (arbiter `FIFO_n_en`)
- `wr_data`  in  WIDTH  word to push (arbiter `instr_out`)
- `rd_ready`  in  1  core accepts `rd_data` this cycle
- `rd_valid`  out  1  head entry present (= !`empty`)
- `rd_data`  out  WIDTH  head entry; zero when empty
- `full`  out  1  `count` == `DEPTH`
- `empty`  out  1  `count` == 0
- `almost_full`  out  1  `count` ≥ `AF_THRESH`
- `count`  out  $clog2(DEPTH)+1  current occupancy, 0..`DEPTH`
- `overflow`  out  1  sticky: a push was dropped
- `clr_overflow`  in  1  synchronous clear of `overflow`

## Operation
- Storage: `DEPTH` × `WIDTH` register array. Pointers `wr_ptr` and `rd_ptr` are $clog2(DEPTH)+1 bits wide; the MSB is the wrap bit. `count` = `wr_ptr` − `rd_ptr` (modulo arithmetic).
- `pop` = `rd_valid` & `rd_ready`. `push` = `wr_en` & (!`full` | `pop`).
- On push, write `mem[wr_ptr]` ← `wr_data` and increment `wr_ptr`. On pop, increment `rd_ptr`. Pointers wrap naturally at 2·`DEPTH`.
- Simultaneous push and pop: both take effect, and `count` is unchanged. This also holds when full: the pop frees the slot, the push is accepted, and `overflow` is not set.
- `wr_en` while full without a pop: the word is dropped, pointers are unchanged, and `overflow` ← 1.
- `rd_ready` while empty: no effect, and `rd_ptr` is unchanged.
- `overflow`: set has priority over `clr_overflow` in the same cycle. Otherwise `clr_overflow` clears it. The flag is held until it is cleared or reset.
- `rd_data` = `mem[rd_ptr[$clog2(DEPTH)-1:0]]` when !`empty`, else 0. It must not expose stale array contents.

## Timing
- Reset (`resetn` low, asynchronous): pointers ← 0 and `overflow` ← 0. Outputs during and after reset: `rd_valid` 0, `rd_data` 0, `full` 0, `empty` 1, `almost_full` 0, `count` 0. Array contents need no reset.
- Reset mid-operation discards all entries immediately. A push in the first edge after release is accepted normally.
- Write-to-read latency is 1 cycle. A word pushed at edge N appears on `rd_data` with `rd_valid`=1 after edge N. No bypass is needed when empty: nothing is visible in the push cycle itself.
- A pop at edge N presents the next entry (or empty) after edge N. Back-to-back pops are sustained at one per cycle.
- `full`, `empty`, `almost_full` and `count` are combinational from registered pointers. They are valid the cycle after the causing edge and are glitch-free with respect to inputs.
- The arbiter has no backpressure input. Upstream uses `almost_full` for throttling, and loss beyond that is flagged only via `overflow`.

## Structure
- Shared package `arb_pkg`: `INSTR_W` = 32, `typedef logic [INSTR_W-1:0] instr_t`, default `FIFO_DEPTH` = 8 and `FIFO_AF` = 6. The arbiter and both FIFO instances share these.
- One sub-module, `fifo_ptr`: a $clog2(DEPTH)+1-bit wrap-bit counter with increment enable and async active-low reset. It is instantiated twice, as the write pointer and the read pointer.
- Top level holds the array, push/pop qualification, flags, and `overflow`.

## Test plan
- Reset, then push 0x11111111, 0x22222222, 0x33333333 with `rd_ready`=0 → `count`=3 and `rd_data`=0x11111111. Then raise `rd_ready` for 3 cycles → words emerge in order, then `empty`=1 and `rd_data`=0.
- Push 8 words with `rd_ready`=0 → `almost_full` rises when `count` reaches 6 and `full`=1 at 8. A 9th push of 0xDEADBEEF → `count` stays 8, `overflow`=1, and 0xDEADBEEF never appears on `rd_data`.
- While full, apply push and `rd_ready` together → `count` stays 8, `overflow` stays 0, and the pushed word emerges last.
- Stream 20 words with `rd_ready`=1 and `wr_en` every cycle → `count` stays ≤ 1, and all 20 words emerge in order across pointer wrap.
- Set `overflow`, then assert `clr_overflow` → `overflow` = 0 next cycle. Assert `clr_overflow` together with a dropped push → `overflow` stays 1.
- With 5 entries queued, drop `resetn` asynchronously mid-cycle → `empty`=1, `count`=0 and `rd_valid`=0 immediately, without waiting for a clock edge.
